// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
// Core-side controller for one padring side. A small register file, written
// and read over a valid/ready register bus, drives the pad dout/oen/ie/cfg
// buses. The returning din bus is synchronized, and enabled rising edges are
// latched into a sticky status register that raises a level interrupt.
//
// Ports:
//   clk, rst       core clock, asynchronous active-high reset
//   reg_valid      request valid
//   reg_ready      request accepted when valid & ready (1 from the first
//                  cycle after reset release)
//   reg_write      1 = write, 0 = read
//   reg_addr       word address
//   reg_wdata      write data
//   reg_rvalid     one-cycle pulse, read data valid
//   reg_rdata      read data, holds its last value between reads
//   din            asynchronous data from the pads
//   dout           data to the pads
//   oen            output enable, active-low
//   ie             input enable (passed straight to the pads)
//   cfg            per-pad config, pad i in bits [i*CFGW +: CFGW]
//   irq            level interrupt

module gpio_pad_ctrl #(
  parameter int NGPIO = 9,
  parameter int CFGW  = 8,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_valid,
  output logic                  reg_ready,
  input  logic                  reg_write,
  input  logic [AW-1:0]         reg_addr,
  input  logic [31:0]           reg_wdata,
  output logic                  reg_rvalid,
  output logic [31:0]           reg_rdata,
  input  logic [NGPIO-1:0]      din,
  output logic [NGPIO-1:0]      dout,
  output logic [NGPIO-1:0]      oen,
  output logic [NGPIO-1:0]      ie,
  output logic [NGPIO*CFGW-1:0] cfg,
  output logic                  irq
);

  localparam logic [AW-1:0] ADDR_OUT        = AW'(8'h00);
  localparam logic [AW-1:0] ADDR_OEN        = AW'(8'h01);
  localparam logic [AW-1:0] ADDR_IE         = AW'(8'h02);
  localparam logic [AW-1:0] ADDR_IN         = AW'(8'h03);
  localparam logic [AW-1:0] ADDR_IRQ_EN     = AW'(8'h04);
  localparam logic [AW-1:0] ADDR_IRQ_STATUS = AW'(8'h05);
  localparam logic [AW-1:0] ADDR_OUT_SET    = AW'(8'h06);
  localparam logic [AW-1:0] ADDR_OUT_CLR    = AW'(8'h07);
  localparam int            CFG_BASE        = 16;

  // Register state
  logic                  ready_q,  ready_d;
  logic [NGPIO-1:0]      out_q,    out_d;
  logic [NGPIO-1:0]      oen_q,    oen_d;
  logic [NGPIO-1:0]      ie_q,     ie_d;
  logic [NGPIO-1:0]      irq_en_q, irq_en_d;
  logic [NGPIO-1:0]      status_q, status_d;
  logic [NGPIO*CFGW-1:0] cfg_q,    cfg_d;

  // Input synchronizer and edge-detect history
  logic [NGPIO-1:0]      s1_q, s1_d;
  logic [NGPIO-1:0]      s2_q, s2_d;
  logic [NGPIO-1:0]      s3_q, s3_d;

  // Bus response and interrupt
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q,  rdata_d;
  logic                  irq_q,    irq_d;

  logic                  wr_fire;
  logic                  rd_fire;
  logic [NGPIO-1:0]      wmask;
  logic [NGPIO-1:0]      w1c;
  logic [NGPIO-1:0]      rise;
  logic [31:0]           rd_mux;

  assign wr_fire = reg_valid & ready_q & reg_write;
  assign rd_fire = reg_valid & ready_q & ~reg_write;
  assign wmask   = reg_wdata[NGPIO-1:0];
  assign rise    = s2_q & ~s3_q;

  // Register writes. OUT_SET/OUT_CLR modify OUT in the same cycle they are
  // accepted, so no other bus access can interleave with the update.
  always_comb begin
    ready_d  = 1'b1;
    out_d    = out_q;
    oen_d    = oen_q;
    ie_d     = ie_q;
    irq_en_d = irq_en_q;
    cfg_d    = cfg_q;
    w1c      = '0;
    if (wr_fire) begin
      case (reg_addr)
        ADDR_OUT:        out_d    = wmask;
        ADDR_OEN:        oen_d    = wmask;
        ADDR_IE:         ie_d     = wmask;
        ADDR_IRQ_EN:     irq_en_d = wmask;
        ADDR_IRQ_STATUS: w1c      = wmask;
        ADDR_OUT_SET:    out_d    = out_q | wmask;
        ADDR_OUT_CLR:    out_d    = out_q & ~wmask;
        default:         ;
      endcase
      for (int i = 0; i < NGPIO; i++) begin
        if (reg_addr == AW'(CFG_BASE + i)) begin
          cfg_d[i*CFGW +: CFGW] = reg_wdata[CFGW-1:0];
        end
      end
    end
  end

  // Input path and interrupt. A new edge is OR-ed in after the clear, so an
  // edge landing in the same cycle as a W1C of that bit keeps the bit set.
  always_comb begin
    s1_d     = din;
    s2_d     = s1_q;
    s3_d     = s2_q;
    status_d = (status_q & ~w1c) | (rise & irq_en_q);
    irq_d    = |(status_q & irq_en_q);
  end

  // Read mux; write-only and unmapped addresses read as zero.
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_OUT:        rd_mux = 32'(out_q);
      ADDR_OEN:        rd_mux = 32'(oen_q);
      ADDR_IE:         rd_mux = 32'(ie_q);
      ADDR_IN:         rd_mux = 32'(s2_q);
      ADDR_IRQ_EN:     rd_mux = 32'(irq_en_q);
      ADDR_IRQ_STATUS: rd_mux = 32'(status_q);
      default:         ;
    endcase
    for (int i = 0; i < NGPIO; i++) begin
      if (reg_addr == AW'(CFG_BASE + i)) begin
        rd_mux = 32'(cfg_q[i*CFGW +: CFGW]);
      end
    end
  end

  always_comb begin
    rvalid_d = rd_fire;
    rdata_d  = rd_fire ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b0;
      out_q    <= '0;
      oen_q    <= '1;
      ie_q     <= '1;
      irq_en_q <= '0;
      status_q <= '0;
      cfg_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      out_q    <= out_d;
      oen_q    <= oen_d;
      ie_q     <= ie_d;
      irq_en_q <= irq_en_d;
      status_q <= status_d;
      cfg_q    <= cfg_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign reg_ready  = ready_q;
  assign reg_rvalid = rvalid_q;
  assign reg_rdata  = rdata_q;
  assign dout       = out_q;
  assign oen        = oen_q;
  assign ie         = ie_q;
  assign cfg        = cfg_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Testbench for gpio_pad_ctrl (NGPIO=9, CFGW=8, AW=5).
// Inputs are driven 1 time unit after each rising edge; outputs are
// sampled at the same offset. Reads push their expected data into a
// queue that a monitor pops when reg_rvalid is due.

module tb_gpio_pad_ctrl;

  localparam int NGPIO = 9;
  localparam int CFGW  = 8;
  localparam int AW    = 5;

  logic                  clk;
  logic                  rst;
  logic                  reg_valid;
  logic                  reg_ready;
  logic                  reg_write;
  logic [AW-1:0]         reg_addr;
  logic [31:0]           reg_wdata;
  logic                  reg_rvalid;
  logic [31:0]           reg_rdata;
  logic [NGPIO-1:0]      din;
  logic [NGPIO-1:0]      dout;
  logic [NGPIO-1:0]      oen;
  logic [NGPIO-1:0]      ie;
  logic [NGPIO*CFGW-1:0] cfg;
  logic                  irq;

  gpio_pad_ctrl #(.NGPIO(NGPIO), .CFGW(CFGW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_valid  (reg_valid),
    .reg_ready  (reg_ready),
    .reg_write  (reg_write),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rvalid (reg_rvalid),
    .reg_rdata  (reg_rdata),
    .din        (din),
    .dout       (dout),
    .oen        (oen),
    .ie         (ie),
    .cfg        (cfg),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read scoreboard: a read accepted at an edge must give rvalid right after
  // that edge, with the data queued when the read was issued.
  logic mon_acc;
  always @(posedge clk) begin
    mon_acc = reg_valid && !reg_write && !rst;
    #1;
    check("rvalid", 128'(reg_rvalid), 128'(mon_acc));
    if (mon_acc) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rdata: rvalid with no expected entry, got 0x%0h (t=%0t)", reg_rdata, $time);
      end else begin
        check("rdata", 128'(reg_rdata), 128'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
    reg_valid = 1'b1;
    reg_write = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(posedge clk);
    #1;
    reg_valid = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input logic [31:0] e);
    reg_valid = 1'b1;
    reg_write = 1'b0;
    reg_addr  = a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    reg_valid = 1'b0;
  endtask

  task automatic bus_read2(input logic [AW-1:0] a, input logic [31:0] ea,
                           input logic [AW-1:0] b, input logic [31:0] eb);
    reg_valid = 1'b1;
    reg_write = 1'b0;
    reg_addr  = a;
    exp_q.push_back(ea);
    @(posedge clk);
    #1;
    reg_addr  = b;
    exp_q.push_back(eb);
    @(posedge clk);
    #1;
    reg_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oen"},    128'(oen),        128'(9'h1FF));
    check({tag, "_ie"},     128'(ie),         128'(9'h1FF));
    check({tag, "_dout"},   128'(dout),       128'(9'h000));
    check({tag, "_cfg"},    128'(cfg),        128'(0));
    check({tag, "_irq"},    128'(irq),        128'(0));
    check({tag, "_rvalid"}, 128'(reg_rvalid), 128'(0));
    check({tag, "_rdata"},  128'(reg_rdata),  128'(0));
    check({tag, "_ready"},  128'(reg_ready),  128'(0));
  endtask

  typedef struct {
    logic [AW-1:0]    addr;
    logic [31:0]      wdata;
    logic [AW-1:0]    rd_addr;
    logic [NGPIO-1:0] exp_dout;
    logic [NGPIO-1:0] exp_oen;
    logic [NGPIO-1:0] exp_ie;
    logic [31:0]      exp_rdata;
  } vec_t;

  vec_t vecs[10];
  logic [NGPIO*CFGW-1:0] exp_cfg;

  initial begin
    vecs[0] = '{5'h00, 32'h0000_00A5, 5'h00, 9'h0A5, 9'h1FF, 9'h1FF, 32'h0000_00A5};
    vecs[1] = '{5'h01, 32'h0000_015A, 5'h01, 9'h0A5, 9'h15A, 9'h1FF, 32'h0000_015A};
    vecs[2] = '{5'h00, 32'h0000_00F0, 5'h00, 9'h0F0, 9'h15A, 9'h1FF, 32'h0000_00F0};
    vecs[3] = '{5'h06, 32'h0000_0003, 5'h06, 9'h0F3, 9'h15A, 9'h1FF, 32'h0000_0000};
    vecs[4] = '{5'h07, 32'h0000_0030, 5'h07, 9'h0C3, 9'h15A, 9'h1FF, 32'h0000_0000};
    vecs[5] = '{5'h02, 32'h0000_00FF, 5'h02, 9'h0C3, 9'h15A, 9'h0FF, 32'h0000_00FF};
    vecs[6] = '{5'h00, 32'hFFFF_FFFF, 5'h00, 9'h1FF, 9'h15A, 9'h0FF, 32'h0000_01FF};
    vecs[7] = '{5'h07, 32'hFFFF_FE00, 5'h00, 9'h1FF, 9'h15A, 9'h0FF, 32'h0000_01FF};
    vecs[8] = '{5'h1A, 32'h0000_0123, 5'h1A, 9'h1FF, 9'h15A, 9'h0FF, 32'h0000_0000};
    vecs[9] = '{5'h07, 32'h0000_0155, 5'h00, 9'h0AA, 9'h15A, 9'h0FF, 32'h0000_00AA};

    rst       = 1'b1;
    reg_valid = 1'b0;
    reg_write = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    din       = '0;

    tick(3);
    check_reset_outputs("por");
    rst = 1'b0;
    check("ready_before_edge", 128'(reg_ready), 128'(0));
    tick(1);
    check("ready_after_release", 128'(reg_ready), 128'(1));

    // Register writes with pad-output and readback checks
    for (int k = 0; k < 10; k++) begin
      bus_write(vecs[k].addr, vecs[k].wdata);
      check($sformatf("v%0d_dout", k), 128'(dout), 128'(vecs[k].exp_dout));
      check($sformatf("v%0d_oen", k),  128'(oen),  128'(vecs[k].exp_oen));
      check($sformatf("v%0d_ie", k),   128'(ie),   128'(vecs[k].exp_ie));
      bus_read(vecs[k].rd_addr, vecs[k].exp_rdata);
    end

    // Back-to-back reads
    bus_read2(5'h01, 32'h0000_015A, 5'h02, 32'h0000_00FF);
    tick(1);

    // Per-pad configuration
    exp_cfg = '0;
    exp_cfg[31:24] = 8'h18;
    exp_cfg[71:64] = 8'hFF;
    bus_write(5'h13, 32'h0000_0118);
    bus_write(5'h18, 32'h0000_00FF);
    check("cfg_after_writes", 128'(cfg), 128'(exp_cfg));
    bus_write(5'h19, 32'h0000_00AB);
    check("cfg_after_0x19", 128'(cfg), 128'(exp_cfg));
    bus_read(5'h19, 32'h0);
    bus_read2(5'h13, 32'h0000_0018, 5'h18, 32'h0000_00FF);

    // Synchronizer latency and interrupt
    bus_write(5'h04, 32'h0000_0004);
    din = 9'h004;
    tick(2);
    bus_read(5'h03, 32'h0000_0004);
    check("irq_not_yet", 128'(irq), 128'(0));
    tick(1);
    check("irq_asserted", 128'(irq), 128'(1));
    bus_read(5'h05, 32'h0000_0004);

    // Edge on a disabled pad is not recorded
    din = 9'h00C;
    tick(5);
    bus_read(5'h05, 32'h0000_0004);
    check("irq_still_set", 128'(irq), 128'(1));

    // W1C clear in the same cycle a new edge on the same pad is detected
    din = 9'h008;
    tick(4);
    din = 9'h00C;
    tick(2);
    bus_write(5'h05, 32'h0000_0004);
    check("race_irq_0", 128'(irq), 128'(1));
    tick(1);
    check("race_irq_1", 128'(irq), 128'(1));
    bus_read(5'h05, 32'h0000_0004);
    check("race_irq_2", 128'(irq), 128'(1));

    // Clear with no edge present
    bus_write(5'h05, 32'h0000_0004);
    tick(1);
    check("clear_irq", 128'(irq), 128'(0));
    bus_read(5'h05, 32'h0);

    // Re-arm, then reset in the middle of activity
    din = 9'h008;
    tick(4);
    din = 9'h00C;
    tick(5);
    check("rearm_irq", 128'(irq), 128'(1));
    bus_write(5'h00, 32'h0000_0155);
    check("pre_reset_dout", 128'(dout), 128'(9'h155));
    bus_read(5'h00, 32'h0000_0155);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    tick(1);
    rst = 1'b0;
    check("mid_ready_before_edge", 128'(reg_ready), 128'(0));
    tick(1);
    check("mid_ready_after_release", 128'(reg_ready), 128'(1));
    bus_read2(5'h00, 32'h0, 5'h01, 32'h0000_01FF);
    bus_read(5'h04, 32'h0);
    tick(5);
    check("post_reset_irq", 128'(irq), 128'(0));
    bus_read(5'h05, 32'h0);

    tick(2);
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
